pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 13 +
 rtl/pc_fetch_unit_inst_buffer.sv | 57 +++++
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 tb/tb_pc_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: default reset PC, instruction
// width and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

  localparam int unsigned InstWidth = 32;
  localparam logic [31:0] DefaultResetPc = 32'h0000_3000;

  typedef enum logic {
    StIdle  = 1'b0,
    StFetch = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_inst_buffer.sv
// One-entry instruction buffer between instruction memory and decode.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   load_i      - capture data_i/pc_i (takes priority over consume_i)
//   consume_i   - decode takes the entry this cycle
//   data_i/pc_i - instruction word and its address to capture
//   valid_o     - entry holds an instruction
//   data_o/pc_o - buffered instruction word and address
module pc_fetch_unit_inst_buffer
  import pc_fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 consume_i,
  input  logic [InstWidth-1:0] data_i,
  input  logic [31:0]          pc_i,
  output logic                 valid_o,
  output logic [InstWidth-1:0] data_o,
  output logic [31:0]          pc_o
);

  logic                 valid_q, valid_d;
  logic [InstWidth-1:0] data_q, data_d;
  logic [31:0]          pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (load_i) begin
      // A load while consuming replaces the entry back-to-back.
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: issues word fetches from pc, buffers one
// instruction for decode and follows branch/jump redirects with one delay
// slot (the fetch already at branch+4 always completes first).
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   imem_req/imem_addr          - fetch request and word address
//   imem_ack/imem_rdata         - fetch completion and instruction word
//   inst_valid/inst/inst_pc     - buffered instruction presented to decode
//   inst_add4                   - inst_pc + 4 for the next-PC calculator
//   stall                       - decode cannot consume this cycle
//   redirect/redirect_pc        - taken branch/jump and its target
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [InstWidth-1:0] imem_rdata,
  output logic                 inst_valid,
  output logic [InstWidth-1:0] inst,
  output logic [31:0]          inst_pc,
  output logic [31:0]          inst_add4,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pending_q, pending_d;
  logic [31:0]  pending_pc_q, pending_pc_d;

  logic consume;
  logic fetch_req;
  logic load;
  logic redirect_acc;

  assign consume = inst_valid & ~stall;
  // Request only when the buffer has room this cycle. While a request waits
  // the buffer stays empty and pc only moves on ack, so req/addr hold.
  assign fetch_req    = (state_q == StFetch) & (~inst_valid | ~stall);
  assign load         = fetch_req & imem_ack;
  assign redirect_acc = redirect & consume & ~pending_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StIdle;
    endcase

    if (load) begin
      pending_d = 1'b0;
      if (redirect_acc) begin
        pc_d = redirect_pc;
      end else if (pending_q) begin
        pc_d = pending_pc_q;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else if (redirect_acc) begin
      // Delay-slot fetch still outstanding: remember the target for later.
      pending_d    = 1'b1;
      pending_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  pc_fetch_unit_inst_buffer u_inst_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .consume_i (consume),
    .data_i    (imem_rdata),
    .pc_i      (pc_q),
    .valid_o   (inst_valid),
    .data_o    (inst),
    .pc_o      (inst_pc)
  );

  assign imem_req  = fetch_req;
  assign imem_addr = pc_q;
  assign inst_add4 = inst_pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: random stall/redirect/memory latency,
// expected instruction stream derived from the delay-slot program-order rule.
module tb_pc_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_add4;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(ResetPc)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_add4   (inst_add4),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  logic [31:0] sb[$];    // expected inst_pc of upcoming consumptions, in order
  logic [31:0] last_pc;  // newest expected pc pushed
  bit          fetch_en;
  bit          mem_slow;
  bit          late_ack;
  bit          mem_busy;
  int          mem_cnt;
  int          force_delay;
  logic [31:0] held_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Instruction k+2 in program order is the redirect
  // target if k is consumed with redirect, else instruction k+1 plus 4.
  task automatic cycle(input logic s, input logic r, input logic [31:0] p);
    logic [31:0] n;
    @(posedge clk);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = p;
    @(negedge clk);
    if (!rst && inst_valid && !stall) begin
      n = r ? p : last_pc + 32'd4;
      sb.push_back(n);
      last_pc = n;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst      = 1'b0;
    late_ack = 1'b0;
    sb.delete();
    sb.push_back(ResetPc);
    sb.push_back(ResetPc + 32'd4);
    last_pc = ResetPc + 32'd4;
    check("idle_req", 32'(imem_req), 32'd0);
    fetch_en = 1'b1;
  endtask

  // Memory model: random latency, address/valid hold checks while waiting.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    held_addr  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mem_busy   = 1'b0;
        imem_ack   = late_ack;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req) begin
        if (!mem_busy) begin
          mem_busy  = 1'b1;
          held_addr = imem_addr;
          if (force_delay >= 0) mem_cnt = force_delay;
          else if (mem_slow && $urandom_range(0, 3) == 0) mem_cnt = int'($urandom_range(1, 4));
          else mem_cnt = 0;
        end else begin
          check("addr_hold", imem_addr, held_addr);
          check("valid_while_wait", 32'(inst_valid), 32'd0);
        end
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          mem_busy   = 1'b0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt--;
        end
      end else begin
        if (mem_busy) begin
          checks++;
          errors++;
          $display("FAIL req_hold actual=0 required=1 addr=%h", held_addr);
          mem_busy = 1'b0;
        end
        // Stray acks with no request must be ignored.
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom();
      end
    end
  end

  // Monitor: pops the scoreboard on every consumption, checks stall freeze.
  initial begin
    logic        hold;
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    logic [31:0] e;
    hold = 1'b0;
    h_inst = '0;
    h_pc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_inst", inst, h_inst);
          check("stall_pc", inst_pc, h_pc);
          check("stall_valid", 32'(inst_valid), 32'd1);
        end
        if (fetch_en) check("req_rule", 32'(imem_req), 32'(!inst_valid || !stall));
        if (inst_valid && !stall) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual_pc=%h required=none", inst_pc);
          end else begin
            e = sb.pop_front();
            check("inst_pc", inst_pc, e);
            check("inst", inst, mem_word(e));
            check("inst_add4", inst_add4, e + 32'd4);
            consumed++;
          end
        end
        hold   = inst_valid && stall;
        h_inst = inst;
        h_pc   = inst_pc;
      end
    end
  end

  initial begin
    logic        s;
    logic        r;
    logic [31:0] p;
    bit          found;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    late_ack    = 1'b0;
    force_delay = -1;
    mem_slow    = 1'b0;
    fetch_en    = 1'b0;
    last_pc     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, ResetPc);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_add4", inst_add4, 32'd4);

    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      check("seq_req", 32'(imem_req), 32'd1);
      check("seq_addr", imem_addr, ResetPc + 32'(4 * i));
    end

    // Random phase: stalls, redirects (some to the top of memory), latency.
    mem_slow = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 4) == 0);
      p = $urandom();
      if ($urandom_range(0, 7) == 0) p = 32'hFFFF_FFFC;
      p[1:0] = 2'b00;
      cycle(s, r, p);
    end

    // Every fetch takes four extra cycles.
    mem_slow    = 1'b0;
    force_delay = 4;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'd0);

    // Reset during an outstanding fetch; a late ack arrives under reset.
    force_delay = 8;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      if (mem_busy && mem_cnt >= 2) found = 1'b1;
    end
    check("outstanding_found", 32'(found), 32'd1);
    #1;
    rst      = 1'b1;
    late_ack = 1'b1;
    fetch_en = 1'b0;
    #1;
    check("abort_req", 32'(imem_req), 32'd0);
    check("abort_addr", imem_addr, ResetPc);
    check("abort_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    force_delay = -1;
    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      check("post_rst_addr", imem_addr, ResetPc + 32'(4 * i));
    end

    mem_slow = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 5) == 0);
      p = $urandom();
      p[1:0] = 2'b00;
      cycle(s, r, p);
    end

    check("progress", 32'(consumed > 600), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
